// File: rtl/ep01_pkg.sv
// Shared types and constants for the 4-input truth-table checker.
package ep01_pkg;

    typedef enum logic [1:0] {
        TT_IDLE   = 2'd0,
        TT_SETTLE = 2'd1,
        TT_SAMPLE = 2'd2,
        TT_DONE   = 2'd3
    } tt_state_t;

    localparam int TT_N_VEC = 16;
    localparam int TT_IDX_W = 4;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-interval down-counter: loads SETTLE-1, counts down while enabled,
// and flags expiry when it reaches zero.
module tt_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expired
);

    localparam logic [3:0] LOAD_VAL = 4'(SETTLE - 1);

    logic [3:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_expired = (r_cnt == 4'd0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps 16 vectors onto a 4-in/1-out unit, captures f into a truth table and
// compares it with EXPECTED. Define TT_CHECKER_STOP_ON_ERR_EN to end on the first mismatch.
module truth_table_checker
    import ep01_pkg::*;
#(
    parameter int          SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_err_idx,
    output logic        err_valid,
    output logic [1:0]  o_dbg_state
);

    localparam logic [TT_IDX_W-1:0] LAST_IDX = TT_IDX_W'(TT_N_VEC - 1);

    // start is a one-cycle request taken only in IDLE; busy acknowledges it from
    // the next cycle until DONE is left, and start seen while busy is dropped.
    tt_state_t           r_state;
    logic [TT_IDX_W-1:0] r_idx;
    logic [3:0]          r_vec;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [15:0]         r_captured;
    logic [4:0]          r_mis_cnt;
    logic [3:0]          r_first_err;
    logic                r_err_valid;

    logic                w_expired;
    logic                w_load;
    logic                w_dec;
    logic                w_mis;
    logic                w_last;
    logic [4:0]          w_mis_cnt_nxt;

    // The timer is held at its load value outside SETTLE so every vector starts fresh.
    assign w_load = (r_state != TT_SETTLE);
    assign w_dec  = (r_state == TT_SETTLE) && !w_expired;

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_load    (w_load),
        .i_dec     (w_dec),
        .o_expired (w_expired)
    );

    always_comb begin
        w_mis         = (f != EXPECTED[r_idx]);
        w_mis_cnt_nxt = r_mis_cnt + {4'd0, w_mis};
`ifdef TT_CHECKER_STOP_ON_ERR_EN
        w_last        = (r_idx == LAST_IDX) || w_mis;
`else
        w_last        = (r_idx == LAST_IDX);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= TT_IDLE;
            r_idx       <= '0;
            r_vec       <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_captured  <= 16'd0;
            r_mis_cnt   <= 5'd0;
            r_first_err <= 4'd0;
            r_err_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TT_IDLE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_vec       <= 4'd0;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_captured  <= 16'd0;
                        r_mis_cnt   <= 5'd0;
                        r_first_err <= 4'd0;
                        r_err_valid <= 1'b0;
                        r_state     <= TT_SETTLE;
                    end
                end
                TT_SETTLE: begin
                    if (w_expired) begin
                        r_state <= TT_SAMPLE;
                    end
                end
                TT_SAMPLE: begin
                    r_captured[r_idx] <= f;
                    if (w_mis) begin
                        r_mis_cnt <= w_mis_cnt_nxt;
                        if (!r_err_valid) begin
                            r_first_err <= r_idx;
                            r_err_valid <= 1'b1;
                        end
                    end
                    // pass uses the post-sample count so it is valid alongside done.
                    if (w_last) begin
                        r_vec   <= 4'd0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_mis_cnt_nxt == 5'd0);
                        r_state <= TT_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_vec   <= r_idx + 1'b1;
                        r_state <= TT_SETTLE;
                    end
                end
                TT_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= TT_IDLE;
                end
                default: r_state <= TT_IDLE;
            endcase
        end
    end

    assign {a, b, c, d}  = r_vec;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign captured      = r_captured;
    assign mismatch_cnt  = r_mis_cnt;
    assign first_err_idx = r_first_err;
    assign err_valid     = r_err_valid;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: four instances cover the passing unit,
// a one-bit expected error, an all-ones response and a short settle interval.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic [3:0][3:0]  vec;
    logic [3:0]       f_v;
    logic [3:0]       busy_v;
    logic [3:0]       done_v;
    logic [3:0]       pass_v;
    logic [3:0][15:0] cap;
    logic [3:0][4:0]  mc;
    logic [3:0][3:0]  fe;
    logic [3:0]       ev;
    logic [3:0][1:0]  st;

    int checks = 0;
    int failures = 0;

    // Hand-computed expectations: f=(a&b)|(c&~d) gives table F444.
    logic [15:0] exp_cap[4];
    int          exp_mc[4];
    logic        exp_ev[4];
    logic        exp_pass[4];
    int          exp_edge[4];

    // Unit under test for each instance.
    assign f_v[0] = (vec[0][3] & vec[0][2]) | (vec[0][1] & ~vec[0][0]);
    assign f_v[1] = (vec[1][3] & vec[1][2]) | (vec[1][1] & ~vec[1][0]);
    assign f_v[2] = 1'b1;
    assign f_v[3] = (vec[3][3] & vec[3][2]) | (vec[3][1] & ~vec[3][0]);

    truth_table_checker #(.SETTLE(2), .EXPECTED(16'hF444)) u_dut0 (
        .clk(clk), .reset(reset), .start(start),
        .a(vec[0][3]), .b(vec[0][2]), .c(vec[0][1]), .d(vec[0][0]), .f(f_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .captured(cap[0]),
        .mismatch_cnt(mc[0]), .first_err_idx(fe[0]), .err_valid(ev[0]), .o_dbg_state(st[0])
    );

    truth_table_checker #(.SETTLE(2), .EXPECTED(16'hF445)) u_dut1 (
        .clk(clk), .reset(reset), .start(start),
        .a(vec[1][3]), .b(vec[1][2]), .c(vec[1][1]), .d(vec[1][0]), .f(f_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .captured(cap[1]),
        .mismatch_cnt(mc[1]), .first_err_idx(fe[1]), .err_valid(ev[1]), .o_dbg_state(st[1])
    );

    truth_table_checker #(.SETTLE(2), .EXPECTED(16'h0000)) u_dut2 (
        .clk(clk), .reset(reset), .start(start),
        .a(vec[2][3]), .b(vec[2][2]), .c(vec[2][1]), .d(vec[2][0]), .f(f_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .captured(cap[2]),
        .mismatch_cnt(mc[2]), .first_err_idx(fe[2]), .err_valid(ev[2]), .o_dbg_state(st[2])
    );

    truth_table_checker #(.SETTLE(1), .EXPECTED(16'hF444)) u_dut3 (
        .clk(clk), .reset(reset), .start(start),
        .a(vec[3][3]), .b(vec[3][2]), .c(vec[3][1]), .d(vec[3][0]), .f(f_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .captured(cap[3]),
        .mismatch_cnt(mc[3]), .first_err_idx(fe[3]), .err_valid(ev[3]), .o_dbg_state(st[3])
    );

    // Leaves the caller at the falling edge right after the start edge (edge 0).
    task automatic start_sweep();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({vec[i], busy_v[i], done_v[i], pass_v[i], cap[i], mc[i], fe[i], ev[i], st[i]} !== 35'd0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d got=%0h exp=0", i,
                         {vec[i], busy_v[i], done_v[i], pass_v[i], cap[i], mc[i], fe[i], ev[i], st[i]});
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_sweep();
        int dn[4];
        int de[4];
        for (int i = 0; i < 4; i++) begin
            dn[i] = 0;
            de[i] = 0;
        end
        start_sweep();
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (done_v[i] === 1'b1) begin
                    dn[i]++;
                    de[i] = k + 1;
                end
            end
            if (k < 48) begin
                checks++;
                if (vec[0] !== 4'(k / 3)) begin
                    failures++;
                    $display("FAIL vec_settle2 k=%0d got=%0h exp=%0h", k, vec[0], 4'(k / 3));
                end
            end
            if (k < 32) begin
                checks++;
                if (vec[3] !== 4'(k / 2)) begin
                    failures++;
                    $display("FAIL vec_settle1 k=%0d got=%0h exp=%0h", k, vec[3], 4'(k / 2));
                end
            end
            checks++;
            if (busy_v[0] !== (k < 49)) begin
                failures++;
                $display("FAIL busy_settle2 k=%0d got=%b exp=%b", k, busy_v[0], (k < 49));
            end
            checks++;
            if (busy_v[3] !== (k < 33)) begin
                failures++;
                $display("FAIL busy_settle1 k=%0d got=%b exp=%b", k, busy_v[3], (k < 33));
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dn[i] != 1 || de[i] != exp_edge[i]) begin
                failures++;
                $display("FAIL done_edge dut%0d got=%0d pulses at edge %0d exp=1 pulse at edge %0d",
                         i, dn[i], de[i], exp_edge[i]);
            end
            checks++;
            if (cap[i] !== exp_cap[i]) begin
                failures++;
                $display("FAIL captured dut%0d got=%h exp=%h", i, cap[i], exp_cap[i]);
            end
            checks++;
            if (mc[i] !== 5'(exp_mc[i])) begin
                failures++;
                $display("FAIL mismatch_cnt dut%0d got=%0d exp=%0d", i, mc[i], exp_mc[i]);
            end
            checks++;
            if (fe[i] !== 4'd0) begin
                failures++;
                $display("FAIL first_err_idx dut%0d got=%0d exp=0", i, fe[i]);
            end
            checks++;
            if (ev[i] !== exp_ev[i]) begin
                failures++;
                $display("FAIL err_valid dut%0d got=%b exp=%b", i, ev[i], exp_ev[i]);
            end
            checks++;
            if (pass_v[i] !== exp_pass[i]) begin
                failures++;
                $display("FAIL pass dut%0d got=%b exp=%b", i, pass_v[i], exp_pass[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        dn = 0;
        start_sweep();
        repeat (19) @(negedge clk);
        // Vectors 0..5 have been sampled by now: low six bits of F444.
        checks++;
        if (cap[0] !== 16'h0004 || busy_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL partial_sweep got cap=%h busy=%b exp cap=0004 busy=1", cap[0], busy_v[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({vec[i], busy_v[i], done_v[i], pass_v[i], cap[i], mc[i], fe[i], ev[i], st[i]} !== 35'd0) begin
                failures++;
                $display("FAIL midsweep_reset dut%0d got=%0h exp=0", i,
                         {vec[i], busy_v[i], done_v[i], pass_v[i], cap[i], mc[i], fe[i], ev[i], st[i]});
            end
        end
        for (int k = 0; k < 60; k++) begin
            if (done_v !== 4'd0) dn++;
            @(negedge clk);
        end
        checks++;
        if (dn != 0) begin
            failures++;
            $display("FAIL no_done_after_reset got=%0d done cycles exp=0", dn);
        end
    endtask

    task automatic test_back_to_back();
        int dn0;
        int dn3;
        int de0[2];
        dn0 = 0;
        dn3 = 0;
        de0[0] = 0;
        de0[1] = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 105; k++) begin
            if (done_v[0] === 1'b1) begin
                if (dn0 < 2) de0[dn0] = k + 1;
                dn0++;
            end
            if (done_v[3] === 1'b1) dn3++;
            checks++;
            if (busy_v[0] !== !(k == 49 || k == 99)) begin
                failures++;
                $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy_v[0], !(k == 49 || k == 99));
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (dn0 != 2 || de0[0] != 49 || de0[1] != 99) begin
            failures++;
            $display("FAIL b2b_done_settle2 got=%0d pulses at %0d,%0d exp=2 pulses at 49,99",
                     dn0, de0[0], de0[1]);
        end
        checks++;
        if (dn3 != 3) begin
            failures++;
            $display("FAIL b2b_done_settle1 got=%0d pulses exp=3", dn3);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (busy_v !== 4'd0) begin
            failures++;
            $display("FAIL b2b_drain got busy=%b exp=0000", busy_v);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            exp_cap[i]  = 16'hF444;
            exp_mc[i]   = 0;
            exp_ev[i]   = 1'b0;
            exp_pass[i] = 1'b1;
            exp_edge[i] = 49;
        end
        exp_edge[3] = 33;
        exp_mc[1]   = 1;
        exp_ev[1]   = 1'b1;
        exp_pass[1] = 1'b0;
        exp_ev[2]   = 1'b1;
        exp_pass[2] = 1'b0;
`ifdef TT_CHECKER_STOP_ON_ERR_EN
        exp_cap[1]  = 16'h0000;
        exp_edge[1] = 4;
        exp_cap[2]  = 16'h0001;
        exp_mc[2]   = 1;
        exp_edge[2] = 4;
`else
        exp_cap[2]  = 16'hFFFF;
        exp_mc[2]   = 16;
`endif

        test_reset();
        test_sweep();
        test_reset_mid();
        test_sweep();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Synthesizable response side of the 4-input combinational exercise flow. The block sweeps all 16 input vectors onto a combinational unit under test, holds each one for a settle interval, and samples the single-bit response `f` into a 16-bit captured truth table. It then compares that table against an expected table and reports pass/fail, the mismatch count and the first failing vector. It sits beside any ep01-style 4-input/1-output function on the board or in a bench.

## Interface
- `SETTLE`, default 2: hold cycles per vector before sampling; legal range 1..15.
- `EXPECTED`, default 16'h0000: expected truth table; bit i is the `f` value for vector i.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- `a`, `b`, `c`, `d`  out  1 each  drive to the unit under test; vector i gives a=i[3], b=i[2], c=i[1], d=i[0].
- `f`  in  1  response from the unit under test.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is left.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  captured table equals `EXPECTED`; valid from `done` until the next accepted `start`.
- `captured`  out  16  sampled truth table.
- `mismatch_cnt`  out  5  number of mismatching vectors, 0..16.
- `first_err_idx`  out  4  index of the lowest-numbered mismatching vector.
- `err_valid`  out  1  at least one mismatch recorded.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE:** `start`=1 sets idx←0 and cnt←0, clears `captured`, `mismatch_cnt`, `err_valid`, `first_err_idx` and `pass`, then goes to SETTLE.
- **SETTLE:** `{a,b,c,d}`=idx. If cnt==SETTLE-1, go to SAMPLE; otherwise cnt←cnt+1.
- **SAMPLE:** `{a,b,c,d}` still equals idx.
  - captured[idx]←f.
  - If f≠EXPECTED[idx]: mismatch_cnt←mismatch_cnt+1. If `err_valid` was 0, set first_err_idx←idx and err_valid←1.
  - If idx==15, go to DONE. Otherwise idx←idx+1, cnt←0, go to SETTLE.
- **DONE:** `done`=1 for exactly this one cycle. `pass`←(mismatch_cnt==0), computed including the final sample. Return to IDLE.
- `{a,b,c,d}` is 0000 in IDLE and DONE.
- Results hold their values in IDLE until the next accepted `start`.
- `start` while `busy` is ignored and is not queued.
- idx is 4 bits and never wraps during a sweep; termination is decided at idx==15.
- `mismatch_cnt` is 5 bits so that 16 mismatches fits without overflow.

## Timing
- Reset values: all outputs 0, state IDLE, idx=0, cnt=0.
- A `reset` asserted mid-sweep aborts the sweep on the next edge. No `done` pulse is issued and partial results are cleared.
- Cycles per vector: SETTLE+1.
- `start` at edge 0 gives `done` at edge 16·(SETTLE+1)+1. With the default SETTLE=2, `done` is at edge 49.
- `busy` is high for 16·(SETTLE+1)+1 cycles. It drops in the cycle after DONE.
- `f` is sampled on the SAMPLE-state edge, which is SETTLE+1 edges after the vector is first driven.
- `start` may be asserted in the cycle right after `done`; the sweep restarts with no gap.

## Configuration
- `TT_CHECKER_STOP_ON_ERR_EN` defined:
  - A SAMPLE that detects a mismatch goes directly to DONE.
  - `pass`=0, `mismatch_cnt`=1, and `first_err_idx` is the failing index.
  - Unsampled bits of `captured` stay 0.
- Not defined: the full 16-vector sweep always runs.

## Structure
- Package `ep01_pkg`:
  - state enum `tt_state_t` (IDLE, SETTLE, SAMPLE, DONE);
  - constant `TT_N_VEC`=16;
  - constant `TT_IDX_W`=4.
- One sub-module, `tt_settle_timer`: a down-counter loaded with SETTLE-1 that outputs `expired`. The FSM, capture register and compare logic stay in the top module.

## Test plan
- Unit under test f=(a&b)|(c&~d), EXPECTED=16'hF444, `start` pulse → `done` at edge 49, `captured`=F444, `pass`=1, `mismatch_cnt`=0, `err_valid`=0.
- Same unit under test, EXPECTED=16'hF445 → `pass`=0, `mismatch_cnt`=1, `first_err_idx`=0, `captured`=F444.
- f tied to 1, EXPECTED=0 → `mismatch_cnt`=16, `first_err_idx`=0. With `TT_CHECKER_STOP_ON_ERR_EN`: `done` at edge 4, `mismatch_cnt`=1, `captured`=0001.
- `reset` asserted 20 cycles after `start` → on the next edge all outputs are 0 and no `done` pulse occurs; a new `start` gives a clean 49-cycle sweep.
- `start` held high for the entire sweep → exactly one `done` per sweep, and a new sweep begins on the edge after `done`.
- SETTLE=1 → `{a,b,c,d}` changes every 2 cycles, `done` at edge 33.
